// File: rtl/mage_stream_agu.sv
// mage_stream_agu: affine loop-nest address generator with lockstep valid/ready, II spacing and abort.
// Optional stall counter enabled by MAGE_AGU_PERF_CNT_EN.
module mage_stream_agu #(
  parameter int N_STREAMS   = 4,
  parameter int N_LP        = 3,
  parameter int NBIT_LP_IV  = 8,
  parameter int NBIT_ADDR   = 16,
  parameter int NBIT_STRIDE = 16,
  parameter int N_BANKS     = 8,
  parameter int NBIT_II     = 4
) (
  input  logic                                               clk_i,
  input  logic                                               rst_n_i,
  input  logic                                               start_i,
  input  logic                                               abort_i,
  input  logic [N_LP*NBIT_LP_IV-1:0]                         reg_lp_bound_i,
  input  logic [NBIT_II-1:0]                                 reg_II_i,
  input  logic [N_STREAMS-1:0]                               reg_stream_en_i,
  input  logic [N_STREAMS*NBIT_ADDR-1:0]                     reg_base_addr_i,
  input  logic [N_STREAMS*N_LP*NBIT_STRIDE-1:0]              reg_stride_i,
  input  logic [N_STREAMS-1:0]                               ready_i,
  output logic [N_STREAMS-1:0]                               valid_o,
  output logic [N_STREAMS*(NBIT_ADDR-$clog2(N_BANKS))-1:0]   addr_o,
  output logic [N_STREAMS*N_BANKS-1:0]                       bank_o,
  output logic                                               last_o,
  output logic                                               busy_o,
  output logic                                               done_o,
  output logic [31:0]                                        stall_cnt_o
);
  localparam int LOG_N_BANKS = $clog2(N_BANKS);
  localparam int NBIT_ROW    = NBIT_ADDR - LOG_N_BANKS;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_II, DONE} state_t;
  state_t state_q, state_d;
  logic [NBIT_LP_IV-1:0] iv_q [N_LP];
  logic [NBIT_LP_IV-1:0] iv_d [N_LP];
  logic [NBIT_ADDR-1:0] off_q [N_STREAMS][N_LP];
  logic [NBIT_ADDR-1:0] off_d [N_STREAMS][N_LP];
  logic [NBIT_ADDR-1:0] sum_c [N_STREAMS];
  logic [NBIT_II-1:0] ii_q, ii_d;
  logic [N_STREAMS-1:0] valid_q, valid_d;
  logic [N_STREAMS*NBIT_ROW-1:0] addr_q, addr_d;
  logic [N_STREAMS*N_BANKS-1:0] bank_q, bank_d;
  logic last_q, last_d, busy_q, busy_d, done_q, done_d;
  logic [N_LP-1:0] at_bnd;
  logic [N_LP:0] low_bnd;
  logic accept;
  // low_bnd[l]: every level below l sits at its bound, so level l steps on accept
  always_comb begin
    accept = &(ready_i | ~reg_stream_en_i);
    low_bnd[0] = 1'b1;
    for (int l = 0; l < N_LP; l++) begin
      at_bnd[l] = iv_q[l] == reg_lp_bound_i[l*NBIT_LP_IV +: NBIT_LP_IV];
      low_bnd[l+1] = low_bnd[l] & at_bnd[l];
    end
    state_d = state_q;
    iv_d = iv_q;
    off_d = off_q;
    ii_d = ii_q;
    if (state_q != IDLE && abort_i) state_d = IDLE;
    else if (state_q == IDLE && start_i) begin
      state_d = ISSUE;
      for (int l = 0; l < N_LP; l++) iv_d[l] = '0;
      for (int s = 0; s < N_STREAMS; s++)
        for (int l = 0; l < N_LP; l++) off_d[s][l] = '0;
    end else if (state_q == ISSUE && accept) begin
      if (low_bnd[N_LP]) state_d = DONE;
      else begin
        state_d = (reg_II_i == '0) ? ISSUE : WAIT_II;
        ii_d = reg_II_i;
        for (int l = 0; l < N_LP; l++)
          if (low_bnd[l]) begin
            iv_d[l] = at_bnd[l] ? '0 : iv_q[l] + 1'b1;
            for (int s = 0; s < N_STREAMS; s++)
              off_d[s][l] = at_bnd[l] ? '0 : off_q[s][l] +
                NBIT_ADDR'($signed(reg_stride_i[(s*N_LP+l)*NBIT_STRIDE +: NBIT_STRIDE]));
          end
      end
    end else if (state_q == WAIT_II) begin
      ii_d = ii_q - 1'b1;
      state_d = (ii_q <= NBIT_II'(1)) ? ISSUE : WAIT_II;
    end else if (state_q == DONE) state_d = IDLE;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    valid_d = (state_d == ISSUE) ? reg_stream_en_i : '0;
    last_d = state_d == ISSUE;
    for (int l = 0; l < N_LP; l++)
      last_d = last_d & (iv_d[l] == reg_lp_bound_i[l*NBIT_LP_IV +: NBIT_LP_IV]);
    addr_d = '0;
    bank_d = '0;
    for (int s = 0; s < N_STREAMS; s++) begin
      sum_c[s] = reg_base_addr_i[s*NBIT_ADDR +: NBIT_ADDR];
      for (int l = 0; l < N_LP; l++) sum_c[s] = sum_c[s] + off_d[s][l];
      addr_d[s*NBIT_ROW +: NBIT_ROW] = busy_d ? sum_c[s][NBIT_ADDR-1:LOG_N_BANKS] : '0;
      bank_d[s*N_BANKS +: N_BANKS] = busy_d ? N_BANKS'(1) << sum_c[s][LOG_N_BANKS-1:0] : '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      ii_q <= '0;
      valid_q <= '0;
      addr_q <= '0;
      bank_q <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int l = 0; l < N_LP; l++) iv_q[l] <= '0;
      for (int s = 0; s < N_STREAMS; s++)
        for (int l = 0; l < N_LP; l++) off_q[s][l] <= '0;
    end else begin
      state_q <= state_d;
      ii_q <= ii_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
      bank_q <= bank_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
      iv_q <= iv_d;
      off_q <= off_d;
    end
  assign valid_o = valid_q;
  assign addr_o = addr_q;
  assign bank_o = bank_q;
  assign last_o = last_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
`ifdef MAGE_AGU_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb
    stall_d = (state_q == IDLE && start_i) ? '0 :
              (state_q == ISSUE && |valid_q && !accept && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) stall_q <= '0;
    else stall_q <= stall_d;
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: doc/mage_stream_agu.md
Name: mage_stream_agu

Overview:
- Parametrised successor address generation unit for the MAGE access path.
- Walks an N_LP-deep perfect loop nest and produces one affine address per enabled stream per iteration: base + sum(iv[l]*stride[l]).
- Each address is split into a bank-interleaved row and bank pair for the multi-bank SpM.
- New versus the previous generation: per-stream valid/ready backpressure in lockstep, programmable initiation interval, signed strides, abort, and done/busy status.

Parameters:
N_STREAMS, 4, number of address streams
N_LP, 3, loop nest depth (level 0 innermost)
NBIT_LP_IV, 8, loop bound width
NBIT_ADDR, 16, word address width
NBIT_STRIDE, 16, signed stride width (must be <= NBIT_ADDR)
N_BANKS, 8, SpM banks (power of two, >= 2); LOG_N_BANKS = $clog2(N_BANKS)
NBIT_II, 4, initiation-interval field width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  start pulse, sampled only in IDLE
abort_i  in  1  synchronous abort, returns to IDLE
reg_lp_bound_i  in  N_LP*NBIT_LP_IV  per-level iteration count minus 1
reg_II_i  in  NBIT_II  idle cycles inserted between iterations
reg_stream_en_i  in  N_STREAMS  stream enable mask
reg_base_addr_i  in  N_STREAMS*NBIT_ADDR  per-stream base word address
reg_stride_i  in  N_STREAMS*N_LP*NBIT_STRIDE  signed per-stream, per-level stride
ready_i  in  N_STREAMS  consumer ready
valid_o  out  N_STREAMS  address valid
addr_o  out  N_STREAMS*(NBIT_ADDR-LOG_N_BANKS)  bank row (address >> LOG_N_BANKS)
bank_o  out  N_STREAMS*N_BANKS  one-hot bank select (address[LOG_N_BANKS-1:0])
last_o  out  1  current iteration is the final one
busy_o  out  1  FSM not in IDLE
done_o  out  1  one-cycle pulse at completion
stall_cnt_o  out  32  backpressure stall count (optional feature)

Behaviour:
- Reset: FSM=IDLE. All outputs and all iv/offset/II counters are 0.
- Config inputs must be stable while busy_o=1; they are not shadowed.
- States: IDLE, ISSUE, WAIT_II, DONE.
- IDLE: start_i=1 clears iv[] and off[][] and enters ISSUE. valid_o rises the next cycle, carrying iteration 0 (address = base). start_i is ignored in any other state.
- ISSUE: valid_o = reg_stream_en_i. All outputs are registered and held stable until accept.
- accept = &(ready_i | ~reg_stream_en_i). With the mask all zero, accept=1 every ISSUE cycle.
- On accept, the loop nest advances:
  - Level l increments when all lower levels are at their bound. Those lower levels wrap to 0.
  - off[s][l] += sign-extended stride[s][l]. off[s][k<l] := 0.
  - New address = base + sum over l of off[s][l], modulo 2^NBIT_ADDR (wrap-around is legal).
- last_o = 1 while every iv[l] equals its bound.
- On accept with last_o=1: go to DONE. valid_o drops next cycle.
- On accept with last_o=0: if reg_II_i=0, stay in ISSUE and present the next iteration next cycle (back-to-back). Otherwise valid_o drops and the FSM enters WAIT_II for reg_II_i cycles, then returns to ISSUE with the next addresses.
- Accepted iterations are therefore spaced exactly reg_II_i+1 cycles apart under full ready.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o=1 in ISSUE, WAIT_II and DONE.
- Minimum run is one iteration (all bounds 0): start -> valid -> accept -> done.
- abort_i (any state except IDLE) has priority over accept. Next cycle: IDLE, valid_o=0, no done_o pulse.
- Asynchronous reset mid-run returns everything to reset values immediately.

Optional Feature:
MAGE_AGU_PERF_CNT_EN
- Defined: stall_cnt_o counts cycles in ISSUE where valid_o != 0 and accept=0.
  - Cleared on accepted start_i.
  - Saturates at 2^32-1.
  - Holds its value after DONE.
- Undefined: stall_cnt_o is tied to 0 and no counter logic exists.

Test Plan:
- Full ready, no II: N_BANKS=8, bounds {L0=2,L1=1,L2=0}, stream 0 base 0x0100, strides {1,16,0}, II=0, all ready -> valid_o[0] high for 6 consecutive cycles starting the cycle after start. Addresses 0x100,0x101,0x102,0x110,0x111,0x112 give row 0x20,0x20,0x20,0x22,0x22,0x22 and bank 0,1,2,0,1,2. last_o with the 6th. done_o pulses the cycle after the 6th accept.
- Lockstep stall: same config, streams 0 and 1 enabled, ready_i[1] low for 3 cycles while 0x102 is presented -> both streams hold 0x102 for 4 cycles. Iterations are not skipped or duplicated. The perf build reports stall_cnt_o=3.
- Initiation interval: II=2, bounds {3,0,0}, all ready -> valid_o pulses exactly 3 cycles apart, 4 accepts total. busy_o is high from the cycle after start through the DONE cycle.
- Negative stride wrap: base 0x0002, stride L0=-1 (0xFFFF), bound 3 -> addresses 0x0002,0x0001,0x0000,0xFFFF. The last gives bank 7, row 0x1FFF.
- Abort and reset: abort_i at the 3rd iteration -> next cycle valid_o=0, busy_o=0, no done_o, and a new start restarts from base. rst_n_i low mid-run -> all outputs 0 asynchronously.
- No streams enabled: mask=0, bounds {1,1,0}, II=1 -> valid_o stays 0, busy_o high, done_o pulses after 4 iterations spaced 2 cycles apart.
